// File: rtl/tm_arch_pkg.sv
// Shared architecture constants and FSM encoding for the Tsetlin-machine
// TA-state fetch path. Users override the defaults through module parameters.
package tm_arch_pkg;

   localparam int unsigned CLAUSES_DEF    = 32'd2000;
   localparam int unsigned LA_CHUNKS_DEF  = 32'd49;
   localparam int unsigned ADDR_WIDTH_DEF = 32'd17;
   localparam int unsigned DATA_WIDTH_DEF = 32'd32;

   // Pass sequencer states: wait for start, stream words, wait for the last
   // word to leave, then pulse done for a single cycle.
   typedef enum logic [1:0] {
      FSM_IDLE  = 2'd0,
      FSM_RUN   = 2'd1,
      FSM_DRAIN = 2'd2,
      FSM_DONE  = 2'd3
   } fsm_state_e;

endpackage : tm_arch_pkg

// File: rtl/ta_index_walker.sv
// Nested clause/chunk index counter. Chunk is the fast index and clause the
// slow one. Both stop at the final position so the indices never leave the
// ROM range.
module ta_index_walker
   import tm_arch_pkg::*;
#(
   parameter int unsigned CLAUSES    = CLAUSES_DEF,
   parameter int unsigned LA_CHUNKS  = LA_CHUNKS_DEF,
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_flag,
   input  logic                  clear,
   input  logic                  advance,
   output logic [ADDR_WIDTH-1:0] clause,
   output logic [ADDR_WIDTH-1:0] chunk,
   output logic                  last
);

   localparam logic [ADDR_WIDTH-1:0] CLAUSE_MAX = ADDR_WIDTH'(CLAUSES - 1);
   localparam logic [ADDR_WIDTH-1:0] CHUNK_MAX  = ADDR_WIDTH'(LA_CHUNKS - 1);

   logic chunk_wrap;

   assign chunk_wrap = (chunk == CHUNK_MAX);
   assign last       = chunk_wrap && (clause == CLAUSE_MAX);

   // Step chunk, roll into the next clause on wrap, and hold at the final word.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst_flag || clear) begin
         clause <= '0;
         chunk  <= '0;
      end else if (advance && !last) begin
         if (chunk_wrap) begin
            chunk  <= '0;
            clause <= clause + 1'b1;
         end else begin
            chunk  <= chunk + 1'b1;
         end
      end
   end

endmodule : ta_index_walker

// File: rtl/ta_fetch_sequencer.sv
// Walks every TA-state word (clause-major, chunk-minor) out of a combinational
// ROM and presents each word on a valid/ready output register. The register
// refills in the same cycle it is drained, so the throughput is one word per
// cycle.
module ta_fetch_sequencer
   import tm_arch_pkg::*;
#(
   parameter int unsigned CLAUSES    = CLAUSES_DEF,
   parameter int unsigned LA_CHUNKS  = LA_CHUNKS_DEF,
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_flag,
   input  logic                  start,
   input  logic                  stop_flag,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   output logic [ADDR_WIDTH-1:0] rom_offset,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH-1:0] out_clause,
   output logic [ADDR_WIDTH-1:0] out_chunk,
   output logic                  out_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done
);

   localparam logic [1:0] ST_IDLE  = FSM_IDLE;
   localparam logic [1:0] ST_RUN   = FSM_RUN;
   localparam logic [1:0] ST_DRAIN = FSM_DRAIN;
   localparam logic [1:0] ST_DONE  = FSM_DONE;

   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic                  capture;
   logic                  transfer;
   logic                  walk_clear;
   logic                  walk_last;
   logic [ADDR_WIDTH-1:0] walk_clause;
   logic [ADDR_WIDTH-1:0] walk_chunk;

   // The output register accepts a new word when it is empty or is being
   // drained this cycle. stop_flag only suppresses refills, never drains.
   assign transfer   = out_valid && out_ready;
   assign capture    = (state == ST_RUN) && !stop_flag && (!out_valid || out_ready);
   assign walk_clear = (state == ST_IDLE) && start;

   ta_index_walker #(
      .CLAUSES    (CLAUSES),
      .LA_CHUNKS  (LA_CHUNKS),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_walker (
      .clk      (clk),
      .rst_flag (rst_flag),
      .clear    (walk_clear),
      .advance  (capture),
      .clause   (walk_clause),
      .chunk    (walk_chunk),
      .last     (walk_last)
   );

   assign rom_addr   = walk_clause;
   assign rom_offset = walk_chunk;
   assign busy       = (state != ST_IDLE);
   assign done       = (state == ST_DONE);

   // Next-state decode for the pass sequencer.
   // NOTE: state_nxt gets a default before the case so that no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start)                state_nxt = ST_RUN;
         ST_RUN:   if (capture && walk_last) state_nxt = ST_DRAIN;
         ST_DRAIN: if (transfer)             state_nxt = ST_DONE;
         ST_DONE:                            state_nxt = ST_IDLE;
         default:                            state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst_flag) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Output word register: load on capture, empty on a transfer with no refill.
   // NOTE: the data fields are reset too, because downstream logic may inspect
   // them while out_valid is low directly after reset.
   always_ff @(posedge clk) begin
      if (rst_flag) begin
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_data   <= '0;
         out_clause <= '0;
         out_chunk  <= '0;
      end else if (capture) begin
         out_valid  <= 1'b1;
         out_last   <= walk_last;
         out_data   <= rom_data;
         out_clause <= walk_clause;
         out_chunk  <= walk_chunk;
      end else if (transfer) begin
         out_valid  <= 1'b0;
      end
   end

endmodule : ta_fetch_sequencer

// File: tb/tb_ta_fetch_sequencer.sv
// Bench for ta_fetch_sequencer with 3 clauses x 2 chunks. The ROM returns
// {clause, chunk}. The expected stream is derived from the index arithmetic
// i -> (i / LA, i % LA).
module tb_ta_fetch_sequencer;

   localparam int CL = 3;
   localparam int LA = 2;
   localparam int AW = 8;
   localparam int DW = 16;
   localparam int NWORDS = CL * LA;

   logic          clk;
   logic          rst_flag, start, stop_flag, out_ready;
   logic [AW-1:0] rom_addr, rom_offset, out_clause, out_chunk;
   logic [DW-1:0] rom_data, out_data;
   logic          out_last, out_valid, busy, done;

   ta_fetch_sequencer #(
      .CLAUSES (CL), .LA_CHUNKS (LA), .ADDR_WIDTH (AW), .DATA_WIDTH (DW)
   ) dut (
      .clk (clk), .rst_flag (rst_flag), .start (start), .stop_flag (stop_flag),
      .rom_addr (rom_addr), .rom_offset (rom_offset), .rom_data (rom_data),
      .out_data (out_data), .out_clause (out_clause), .out_chunk (out_chunk),
      .out_last (out_last), .out_valid (out_valid), .out_ready (out_ready),
      .busy (busy), .done (done)
   );

   assign rom_data = {rom_addr, rom_offset};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct { int c; int k; logic l; } word_t;
   word_t sb[$];
   int    done_cnt;
   logic  saw_done;
   logic  prev_hold, prev_last_xfer, prev_last;
   logic [DW-1:0] prev_data;
   logic [AW-1:0] prev_clause, prev_chunk;

   typedef struct {
      logic start; logic ready;
      logic exp_valid; int exp_clause; int exp_chunk; logic exp_last;
      logic exp_busy; logic exp_done;
   } vec_t;
   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic clear_sb();
      sb.delete();
      done_cnt = 0; saw_done = 0;
      prev_hold = 0; prev_last_xfer = 0;
   endtask

   // Observe one cycle: stability while stalled, word integrity, transfers, done.
   task automatic monitor(input logic r);
      if (prev_hold) begin
         check("hold_valid", out_valid, 1'b1);
         check("hold_word", {out_data, out_clause, out_chunk, out_last},
               {prev_data, prev_clause, prev_chunk, prev_last});
      end
      if (out_valid) begin
         check("word_integrity", out_data, {out_clause, out_chunk});
         check("last_flag", out_last, (out_clause == AW'(CL-1)) && (out_chunk == AW'(LA-1)));
      end
      if (!r && out_valid && out_ready) sb.push_back('{int'(out_clause), int'(out_chunk), out_last});
      if (done) begin
         done_cnt++; saw_done = 1;
         check("done_after_last", prev_last_xfer, 1'b1);
      end
      prev_last_xfer = !r && out_valid && out_ready && out_last;
      prev_hold      = !r && out_valid && !out_ready;
      prev_data = out_data; prev_clause = out_clause; prev_chunk = out_chunk; prev_last = out_last;
   endtask

   task automatic drive_sample(input logic r, input logic st, input logic sp, input logic rd);
      rst_flag = r; start = st; stop_flag = sp; out_ready = rd;
      @(negedge clk);
      monitor(r);
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      for (int i = 0; i < 2; i++) begin
         drive_sample(1'b1, 1'b1, 1'b0, 1'b0);
         advance();
      end
      clear_sb();
   endtask

   task automatic check_word(input string name, input int c, input int k);
      check({name, "_valid"}, out_valid, 1'b1);
      check({name, "_idx"}, {out_clause, out_chunk}, {AW'(c), AW'(k)});
   endtask

   // Reference stream: word i is (i / LA, i % LA), last only on the final word.
   task automatic verify_pass(input string tag);
      check({tag, "_nwords"}, sb.size(), NWORDS);
      for (int i = 0; i < NWORDS && i < sb.size(); i++) begin
         check({tag, "_order"}, {sb[i].c, sb[i].k}, {i / LA, i % LA});
         check({tag, "_last"}, sb[i].l, i == NWORDS - 1);
      end
      check({tag, "_done_pulses"}, done_cnt, 1);
   endtask

   // Finish a pass with random ready/stop/start, bounded by a cycle budget.
   task automatic run_to_done(input int p_ready, input int p_stop, input int p_start, input int budget);
      int n;
      n = 0;
      while (!saw_done && n < budget) begin
         drive_sample(1'b0, $urandom_range(0, 99) < p_start, $urandom_range(0, 99) < p_stop,
                      $urandom_range(0, 99) < p_ready);
         advance();
         n++;
      end
      if (!saw_done) check("pass_timeout", 32'd0, 32'd1);
      drive_sample(1'b0, 1'b0, 1'b0, 1'b1);
      check("idle_after_done", {busy, done, out_valid}, 3'b000);
      advance();
   endtask

   task automatic run_table(input string tag);
      for (int i = 0; i < 10; i++) begin
         drive_sample(1'b0, vecs[i].start, 1'b0, vecs[i].ready);
         check({tag, "_valid"}, out_valid, vecs[i].exp_valid);
         check({tag, "_busy"}, busy, vecs[i].exp_busy);
         check({tag, "_done"}, done, vecs[i].exp_done);
         if (vecs[i].exp_valid) begin
            check({tag, "_idx"}, {out_clause, out_chunk}, {AW'(vecs[i].exp_clause), AW'(vecs[i].exp_chunk)});
            check({tag, "_data"}, out_data, DW'((vecs[i].exp_clause << 8) | vecs[i].exp_chunk));
            check({tag, "_olast"}, out_last, vecs[i].exp_last);
         end
         advance();
      end
   endtask

   initial begin
      rst_flag = 1'b1; start = 1'b0; stop_flag = 1'b0; out_ready = 1'b0;
      clear_sb();

      // start in cycle 0, first word in cycle 2, one word per cycle, done after the last transfer
      vecs[0] = '{1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 1'b1, 0, 1, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 1'b1, 1, 0, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 1'b1, 1, 1, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 1'b1, 1'b1, 2, 0, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{1'b0, 1'b1, 1'b1, 2, 1, 1'b1, 1'b1, 1'b0};
      vecs[8] = '{1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1};
      vecs[9] = '{1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};

      // Reset state; start is held high alongside reset, and reset must win.
      do_reset();
      drive_sample(1'b0, 1'b0, 1'b0, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_valid", out_valid, 1'b0);
      check("rst_last", out_last, 1'b0);
      check("rst_out", {out_data, out_clause, out_chunk}, '0);
      check("rst_idx", {rom_addr, rom_offset}, '0);
      advance();

      // Straight pass.
      clear_sb();
      run_table("tbl_plain");
      verify_pass("tbl_plain");

      // Same pass with start held through RUN and DRAIN: no restart.
      do_reset();
      for (int i = 0; i < 8; i++) vecs[i].start = 1'b1;
      run_table("tbl_start_held");
      verify_pass("tbl_start_held");

      // out_ready low for 3 cycles while (1,0) is presented.
      do_reset();
      drive_sample(1'b0, 1'b1, 1'b0, 1'b1); advance();
      for (int i = 0; i < 3; i++) begin drive_sample(1'b0, 1'b0, 1'b0, 1'b1); advance(); end
      for (int i = 0; i < 3; i++) begin
         drive_sample(1'b0, 1'b0, 1'b0, 1'b0);
         check_word("stall_hold", 1, 0);
         advance();
      end
      drive_sample(1'b0, 1'b0, 1'b0, 1'b1); check_word("stall_release", 1, 0); advance();
      drive_sample(1'b0, 1'b0, 1'b0, 1'b1); check_word("stall_resume", 1, 1); advance();
      run_to_done(100, 0, 0, 50);
      verify_pass("stall");

      // stop_flag high for 2 cycles while (1,0) is pending.
      do_reset();
      drive_sample(1'b0, 1'b1, 1'b0, 1'b1); advance();
      for (int i = 0; i < 3; i++) begin drive_sample(1'b0, 1'b0, 1'b0, 1'b1); advance(); end
      drive_sample(1'b0, 1'b0, 1'b1, 1'b1); check_word("stop_pending", 1, 0); advance();
      drive_sample(1'b0, 1'b0, 1'b1, 1'b1);
      check("stop_valid_drop", out_valid, 1'b0);
      check("stop_idx_frozen", {rom_addr, rom_offset}, {AW'(1), AW'(1)});
      advance();
      drive_sample(1'b0, 1'b0, 1'b0, 1'b1);
      check("stop_release_valid", out_valid, 1'b0);
      check("stop_release_idx", {rom_addr, rom_offset}, {AW'(1), AW'(1)});
      advance();
      drive_sample(1'b0, 1'b0, 1'b0, 1'b1); check_word("stop_resume", 1, 1); advance();
      run_to_done(100, 0, 0, 50);
      verify_pass("stop");

      // Reset while (1,1) is presented, with start also high; then a clean restart.
      do_reset();
      drive_sample(1'b0, 1'b1, 1'b0, 1'b1); advance();
      for (int i = 0; i < 4; i++) begin drive_sample(1'b0, 1'b0, 1'b0, 1'b1); advance(); end
      drive_sample(1'b0, 1'b0, 1'b0, 1'b1);
      check_word("midrst_pre", 1, 1);
      rst_flag = 1'b1; start = 1'b1;
      advance();
      drive_sample(1'b0, 1'b0, 1'b0, 1'b1);
      check("midrst_busy", busy, 1'b0);
      check("midrst_valid", out_valid, 1'b0);
      check("midrst_done", done, 1'b0);
      check("midrst_idx", {rom_addr, rom_offset}, '0);
      check("midrst_out", {out_data, out_clause, out_chunk, out_last}, '0);
      advance();
      clear_sb();
      drive_sample(1'b0, 1'b1, 1'b0, 1'b1); advance();
      run_to_done(100, 0, 0, 50);
      verify_pass("midrst_restart");

      // Random ready/stop/start patterns against the reference stream.
      for (int p = 0; p < 8; p++) begin
         do_reset();
         drive_sample(1'b0, 1'b1, 1'b0, 1'b1); advance();
         run_to_done($urandom_range(30, 100), $urandom_range(0, 50), 30, 400);
         verify_pass("random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_ta_fetch_sequencer

// File: doc/ta_fetch_sequencer.md
TA_FETCH_SEQUENCER -- requirements
Module: ta_fetch_sequencer

Interface
REQ-001 Parameter CLAUSES, default 17'h007D0 (2000), number of clauses to walk.
REQ-002 Parameter LA_CHUNKS, default 17'h00031 (49), TA-state chunks per clause.
REQ-003 Parameter ADDR_WIDTH, default 17, width of clause/chunk indices.
REQ-004 Parameter DATA_WIDTH, default 32, width of one TA-state ROM word.
REQ-005 Port clk  input  1  sole clock; all state on rising edge.
REQ-006 Port rst_flag  input  1  reset, synchronous, active-high.
REQ-007 Port start  input  1  begin one full pass when idle.
REQ-008 Port stop_flag  input  1  pause; while high no new ROM word is captured.
REQ-009 Port rom_addr  output  ADDR_WIDTH  current clause index to the TA-state ROM.
REQ-010 Port rom_offset  output  ADDR_WIDTH  current chunk index to the TA-state ROM.
REQ-011 Port rom_data  input  DATA_WIDTH  ROM word, combinational from rom_addr/rom_offset.
REQ-012 Port out_data  output  DATA_WIDTH  registered TA-state word.
REQ-013 Port out_clause / out_chunk  output  ADDR_WIDTH each  indices belonging to out_data.
REQ-014 Port out_last  output  1  out_data is chunk LA_CHUNKS-1 of clause CLAUSES-1.
REQ-015 Port out_valid  input-side out_ready; out_valid output 1, out_ready input 1  downstream handshake.
REQ-016 Port busy  output  1  high in any state except IDLE.
REQ-017 Port done  output  1  one-cycle pulse at pass completion.

Function
REQ-018 FSM states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-019 IDLE: start=1 clears clause/chunk indices to 0 and moves to RUN next cycle; start ignored in all other states.
REQ-020 RUN: capture fires when stop_flag=0 and (out_valid=0 or out_ready=1); captures rom_data, rom_addr, rom_offset and last-flag into output registers and sets out_valid=1.
REQ-021 On capture, chunk increments; at LA_CHUNKS-1 chunk wraps to 0 and clause increments; no index ever exceeds its limit minus 1.
REQ-022 Capture of the last word (clause CLAUSES-1, chunk LA_CHUNKS-1) moves RUN to DRAIN; indices hold.
REQ-023 Output transfer occurs when out_valid=1 and out_ready=1; out_valid clears on transfer unless a capture fires the same cycle.
REQ-024 out_data/out_clause/out_chunk/out_last hold stable while out_valid=1 and out_ready=0.
REQ-025 stop_flag=1 blocks capture only; a pending out_valid still transfers on out_ready.
REQ-026 DRAIN: on transfer of the last word go to DONE; DONE asserts done for exactly one cycle and returns to IDLE.
REQ-027 Throughput one word per cycle with out_ready held 1 and stop_flag 0; start at cycle T gives first out_valid at T+2.
REQ-028 Full pass emits exactly CLAUSES*LA_CHUNKS words in clause-major, chunk-minor order; no drop, no duplicate under any stall pattern.

Reset
REQ-029 rst_flag=1 at any cycle, including mid-pass, forces IDLE, indices 0, out_valid 0, out_last 0, out_data/out_clause/out_chunk 0, busy 0, done 0 on the next edge; rst_flag dominates start.

Structure
REQ-030 Shared package tm_arch_pkg holds CLAUSES, LA_CHUNKS, ADDR_WIDTH, DATA_WIDTH defaults and the FSM state enum.
REQ-031 One sub-module ta_index_walker owns the nested chunk/clause counters with clear, advance and last outputs; the FSM and output register stay in ta_fetch_sequencer.

Verification (CLAUSES=3, LA_CHUNKS=2, ROM word = {clause,chunk} pattern)
REQ-032 start pulse, out_ready=1 -> 6 words (0,0),(0,1),(1,0),(1,1),(2,0),(2,1) on consecutive cycles, out_last only on (2,1), done one cycle after its transfer.
REQ-033 out_ready=0 for 3 cycles after word (1,0) -> (1,0) held stable 3 cycles, then sequence resumes at (1,1) with no loss.
REQ-034 stop_flag=1 for 2 cycles mid-pass, out_ready=1 -> out_valid drops after pending transfer, indices frozen, resumes at next index.
REQ-035 rst_flag=1 while at (1,1) -> next cycle busy=0, out_valid=0, indices 0; following start restarts at (0,0).
REQ-036 start asserted during RUN and in DRAIN -> no restart, still exactly 6 words and a single done pulse.
